skinny_rnd_ctrl: RTL and testbench

//  Sequencer for the unrolled SKINNY-128-384 round datapath (NUMRND rounds/cycle, full-width TK1 counter).

---
 rtl/skinny_rnd_ctrl.sv | 132 +++++++++++++
 tb/tb_skinny_rnd_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_rnd_ctrl.sv
// Round sequencer for an unrolled SKINNY-128-384 datapath: holds state/TK registers and the
// round-constant LFSR, feeds NUMRND rounds per cycle and captures the results until done.
module skinny_rnd_ctrl #(
    parameter int unsigned NUMRND = 4,
    parameter int unsigned ROUNDS = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          pt_i,
    input  logic [127:0]          tk1_i,
    input  logic [127:0]          tk2_i,
    input  logic [127:0]          tk3_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ct_o,
    output logic [127:0]          dp_state,
    output logic [127:0]          dp_cnt,
    output logic [127:0]          dp_tweak,
    output logic [127:0]          dp_key,
    output logic [6*NUMRND-1:0]   dp_const,
    input  logic [127:0]          dp_nstate,
    input  logic [127:0]          dp_ncnt,
    input  logic [127:0]          dp_ntweak,
    input  logic [127:0]          dp_nkey
);

    localparam int unsigned NCYC = ROUNDS / NUMRND;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CycLast = CW'(NCYC - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        fsm_q, fsm_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  cnt_q, cnt_d;
    logic [127:0]  tweak_q, tweak_d;
    logic [127:0]  key_q, key_d;
    logic [5:0]    rc_q, rc_d;
    logic [5:0]    rc_adv;
    logic [CW-1:0] cyc_q, cyc_d;

    function automatic logic [5:0] lfsr_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // Constants for the NUMRND rounds of this cycle, plus the LFSR value after all of them.
    always_comb begin : rc_unroll
        logic [5:0] r;
        r        = rc_q;
        dp_const = '0;
        for (int i = 0; i < NUMRND; i++) begin
            r = lfsr_step(r);
            dp_const[6*i +: 6] = r;
        end
        rc_adv = r;
    end

    always_comb begin
        fsm_d     = fsm_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        tweak_d   = tweak_q;
        key_d     = key_q;
        rc_d      = rc_q;
        cyc_d     = cyc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = pt_i;
                    cnt_d   = tk1_i;
                    tweak_d = tk2_i;
                    key_d   = tk3_i;
                    rc_d    = '0;
                    cyc_d   = '0;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                st_d    = dp_nstate;
                cnt_d   = dp_ncnt;
                tweak_d = dp_ntweak;
                key_d   = dp_nkey;
                rc_d    = rc_adv;
                // Counter parks on its terminal value rather than wrapping.
                if (cyc_q == CycLast) begin
                    fsm_d = StDone;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StIdle;
            st_q    <= '0;
            cnt_q   <= '0;
            tweak_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            cyc_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            tweak_q <= tweak_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ct_o     = st_q;
    assign dp_state = st_q;
    assign dp_cnt   = cnt_q;
    assign dp_tweak = tweak_q;
    assign dp_key   = key_q;

endmodule

// File: tb/tb_skinny_rnd_ctrl.sv
// Bench for skinny_rnd_ctrl: a stand-in unrolled round datapath plus a per-round reference
// model of the whole encryption, driven with directed and random blocks.
module tb_skinny_rnd_ctrl;

    localparam int unsigned NUMRND = 4;
    localparam int unsigned ROUNDS = 40;
    localparam int LAT    = ROUNDS / NUMRND + 1;
    localparam int PERIOD = ROUNDS / NUMRND + 2;

    typedef struct packed {
        logic [127:0] s;
        logic [127:0] c;
        logic [127:0] t;
        logic [127:0] k;
    } blk_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        pt, tk1, tk2, tk3;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        ct;
    logic [127:0]        dp_state, dp_cnt, dp_tweak, dp_key;
    logic [6*NUMRND-1:0] dp_const;
    logic [127:0]        dp_nstate, dp_ncnt, dp_ntweak, dp_nkey;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    skinny_rnd_ctrl #(.NUMRND(NUMRND), .ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_i      (pt),
        .tk1_i     (tk1),
        .tk2_i     (tk2),
        .tk3_i     (tk3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_o      (ct),
        .dp_state  (dp_state),
        .dp_cnt    (dp_cnt),
        .dp_tweak  (dp_tweak),
        .dp_key    (dp_key),
        .dp_const  (dp_const),
        .dp_nstate (dp_nstate),
        .dp_ncnt   (dp_ncnt),
        .dp_ntweak (dp_ntweak),
        .dp_nkey   (dp_nkey)
    );

    // Stand-in round: nonlinear, and sensitive to each round's own constant.
    function automatic blk_t round_f(input blk_t b, input logic [5:0] rc);
        blk_t r;
        r.s = {b.s[120:0], b.s[127:121]} ^ (b.c + b.t) ^ (b.k & ~b.s) ^ {rc, 58'h0, rc, 58'h0};
        r.c = b.c + 128'd1;
        r.t = {b.t[114:0], b.t[127:115]} ^ b.c;
        r.k = {b.k[98:0], b.k[127:99]} + b.t;
        return r;
    endfunction

    always_comb begin : datapath
        blk_t b;
        b = {dp_state, dp_cnt, dp_tweak, dp_key};
        for (int i = 0; i < NUMRND; i++) begin
            b = round_f(b, dp_const[6*i +: 6]);
        end
        dp_nstate = b.s;
        dp_ncnt   = b.c;
        dp_ntweak = b.t;
        dp_nkey   = b.k;
    end

    // Whole encryption, one round at a time with the constant sequence built from the LFSR rule.
    function automatic logic [127:0] ref_ct(input logic [127:0] p, input logic [127:0] a,
                                            input logic [127:0] b2, input logic [127:0] k);
        blk_t       b;
        logic [5:0] rc;
        b  = {p, a, b2, k};
        rc = 6'h00;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            b  = round_f(b, rc);
        end
        return b.s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one block from IDLE, measures latency, optionally stalls the output, drains it.
    task automatic run_block(input int stall);
        logic [127:0] exp;
        int           lat;
        pt  = rand128();
        tk1 = rand128();
        tk2 = rand128();
        tk3 = rand128();
        exp = ref_ct(pt, tk1, tk2, tk3);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        next_cyc();
        in_valid = 1'b0;
        pt  = rand128();
        lat = 1;
        while (!out_valid && lat < 4 * LAT) begin
            next_cyc();
            lat++;
        end
        check("latency", 128'(lat), 128'(LAT));
        check("ct", ct, exp);
        for (int i = 0; i < stall; i++) next_cyc();
        if (stall > 0) begin
            check("ct_after_stall", ct, exp);
            out_ready = 1'b1;
        end
        next_cyc();
        check("idle_after_handshake", 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin : stim
        logic [127:0] exp;
        logic [127:0] eq[$];
        int           lat, cyc, prev, got, seen_ov;
        logic         accepted;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pt = '0; tk1 = '0; tk2 = '0; tk3 = '0;
        next_cyc();
        next_cyc();
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_dp_state", dp_state, '0);
        check("rst_dp_const", 128'(dp_const), 128'(24'h3C70C1));
        rst = 1'b0;

        // First two cycles of a run: loaded operands and round constants.
        pt = rand128(); tk1 = rand128(); tk2 = rand128(); tk3 = rand128();
        exp = ref_ct(pt, tk1, tk2, tk3);
        in_valid = 1'b1;
        check("idle_ready", 128'(in_ready), 128'(1'b1));
        next_cyc();
        in_valid = 1'b0;
        check("run0_state", dp_state, pt);
        check("run0_cnt", dp_cnt, tk1);
        check("run0_key", dp_key, tk3);
        check("run0_const", 128'(dp_const), 128'(24'h3C70C1));
        check("run_not_ready", 128'(in_ready), 128'(1'b0));
        pt = '0; tk1 = '0; tk2 = '0; tk3 = '0;
        next_cyc();
        check("run1_const", 128'(dp_const), 128'(24'hEFDF9F));
        lat = 2;
        while (!out_valid && lat < 4 * LAT) begin
            next_cyc();
            lat++;
        end
        check("first_latency", 128'(lat), 128'(LAT));
        check("first_ct", ct, exp);
        next_cyc();

        // Backpressure: hold DONE for 20 cycles while a new request knocks.
        pt = rand128(); tk1 = rand128(); tk2 = rand128(); tk3 = rand128();
        exp = ref_ct(pt, tk1, tk2, tk3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        next_cyc();
        lat = 1;
        while (!out_valid && lat < 4 * LAT) begin
            next_cyc();
            lat++;
        end
        check("bp_latency", 128'(lat), 128'(LAT));
        for (int i = 0; i < 20; i++) begin
            pt = rand128();
            check("bp_hold", {ct[127:2], out_valid, in_ready}, {exp[127:2], 2'b10});
            next_cyc();
        end
        check("bp_ct", ct, exp);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        next_cyc();
        check("bp_released", 128'({out_valid, in_ready}), 128'(2'b01));
        check("bp_no_load", dp_state, exp);

        // Reset mid-run, with a request present during reset.
        run_block(0);
        pt = rand128(); tk1 = rand128(); tk2 = rand128(); tk3 = rand128();
        in_valid = 1'b1;
        next_cyc();
        for (int i = 0; i < 3; i++) next_cyc();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        check("midrst_ready", 128'(in_ready), 128'(1'b1));
        check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_dp_state", dp_state, '0);
        check("midrst_dp_const", 128'(dp_const), 128'(24'h3C70C1));
        rst = 1'b0;
        in_valid = 1'b0;
        seen_ov = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (out_valid) seen_ov++;
            next_cyc();
        end
        check("aborted_no_output", 128'(seen_ov), 128'(0));

        // Back-to-back: request always pending, consumer always ready.
        pt = rand128(); tk1 = rand128(); tk2 = rand128(); tk3 = rand128();
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0; prev = -1; got = 0;
        while (got < 5 && cyc < 40 * PERIOD) begin
            accepted = in_ready;
            if (accepted) eq.push_back(ref_ct(pt, tk1, tk2, tk3));
            if (out_valid) begin
                if (eq.size() > 0) check("b2b_ct", ct, eq.pop_front());
                else check("b2b_unexpected_output", 128'(1), 128'(0));
                if (prev >= 0) check("b2b_period", 128'(cyc - prev), 128'(PERIOD));
                prev = cyc;
                got++;
            end
            next_cyc();
            cyc++;
            if (accepted) begin
                pt = rand128(); tk1 = rand128(); tk2 = rand128(); tk3 = rand128();
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(got), 128'(5));

        for (int n = 0; n < 1000; n++) run_block(($urandom_range(0, 3) == 0) ? 2 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
